// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parametrised TX serializer.
// Holds the default word width, the K28.5 comma encodings and the slot-to-bit mapping.
package piso_pkg;

    localparam int unsigned DEFAULT_DATA_W = 10;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // Maps transmit slot k (counting down from width-1) to the word bit it carries.
    function automatic int unsigned slot_idx(input int unsigned k, input bit msb_first,
                                             input int unsigned width);
        return msb_first ? k : (width - 1 - k);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding buffer in front of the shifter: valid/ready intake, drained at word
// boundaries and refillable on the same edge.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              boundary_i,
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_ready_o,
    output logic              hold_vld_o,
    output logic [DATA_W-1:0] hold_data_o
);

    logic              hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tx_ready;
    logic              accept;

    always_comb begin
        tx_ready   = rst_ni && (!hold_vld_q || boundary_i);
        accept     = tx_valid_i && tx_ready;
        hold_d     = accept ? tx_data_i : hold_q;
        // A boundary consumes the held word, so only this cycle's accept survives it.
        hold_vld_d = boundary_i ? accept : (hold_vld_q || accept);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

    assign tx_ready_o  = tx_ready;
    assign hold_vld_o  = hold_vld_q;
    assign hold_data_o = hold_q;

endmodule

// File: rtl/piso_serializer_param.sv
// Parametrised PISO for the SerDes TX path: shifts buffered words onto Serial and inserts
// IDLE_WORD (flagged by Underrun) whenever no word is waiting at a word boundary.
module piso_serializer_param
    import piso_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(K28_5_RDN),
    localparam int unsigned      CNT_W     = $clog2(DATA_W)
) (
    input  logic              BitCLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] TxParallel,
    input  logic              TxValid,
    output logic              TxReady,
    output logic              Serial,
    output logic [CNT_W-1:0]  bit_count,
    output logic              Underrun
);

    localparam logic [CNT_W-1:0] LastSlot = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FirstIdx = CNT_W'(slot_idx(DATA_W - 1, MSB_FIRST, DATA_W));

    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic              serial_q, serial_d;
    logic              underrun_q, underrun_d;

    logic              boundary;
    logic              hold_vld;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] next_word;
    logic [CNT_W-1:0]  cnt_m1;
    logic [CNT_W-1:0]  slot;

    piso_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk_i       (BitCLK),
        .rst_ni      (Reset),
        .boundary_i  (boundary),
        .tx_valid_i  (TxValid),
        .tx_data_i   (TxParallel),
        .tx_ready_o  (TxReady),
        .hold_vld_o  (hold_vld),
        .hold_data_o (hold_q)
    );

    always_comb begin
        boundary  = (bit_count_q == '0);
        next_word = hold_vld ? hold_q : IDLE_WORD;
        cnt_m1    = bit_count_q - CNT_W'(1);
        slot      = CNT_W'(slot_idx(32'(cnt_m1), MSB_FIRST, DATA_W));

        word_d      = word_q;
        bit_count_d = cnt_m1;
        serial_d    = word_q[slot];
        underrun_d  = 1'b0;

        if (boundary) begin
            word_d      = next_word;
            bit_count_d = LastSlot;
            serial_d    = next_word[FirstIdx];
            underrun_d  = !hold_vld;
        end
    end

    always_ff @(posedge BitCLK or negedge Reset) begin
        if (!Reset) begin
            word_q      <= '0;
            bit_count_q <= '0;
            serial_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            word_q      <= word_d;
            bit_count_q <= bit_count_d;
            serial_q    <= serial_d;
            underrun_q  <= underrun_d;
        end
    end

    assign Serial    = serial_q;
    assign bit_count = bit_count_q;
    assign Underrun  = underrun_q;

endmodule
